// File: rtl/cache_mem_bridge_pkg.sv
// Shared types for the cache-to-RAM bridge: FSM state encoding, default widths
// and the write-buffer entry layout.
package cache_mem_pkg;

  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 32;
  localparam int WB_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    DRAIN    = 2'd3
  } bridge_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/cache_mem_bridge_write_buffer.sv
// Write-back FIFO with wrap-bit pointers; with CACHE_BRIDGE_FWD_EN it also
// exposes a youngest-match address lookup for read forwarding.
module write_buffer
  import cache_mem_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEF
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      i_push,
  input  wb_entry_t i_push_entry,
  input  logic      i_pop,
  output wb_entry_t o_head,
  output logic      o_full,
  output logic      o_empty
`ifdef CACHE_BRIDGE_FWD_EN
  ,
  input  logic [ADDR_W-1:0] i_lookup_addr,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_hit_data
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  wb_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                   (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[IW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // NOTE: storage is left unreset; the pointers alone decide which slots hold live data.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[IW-1:0]] <= i_push_entry;
  end

`ifdef CACHE_BRIDGE_FWD_EN
  logic [PW-1:0] w_count;
  assign w_count = r_wr_ptr - r_rd_ptr;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    logic [PW-1:0] idx;
    // NOTE: every output gets a default before the loop so no latch is inferred.
    o_hit      = 1'b0;
    o_hit_data = '0;
    idx        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_rd_ptr + PW'(k);
      if ((PW'(k) < w_count) && (r_mem[idx[IW-1:0]].addr == i_lookup_addr)) begin
        o_hit      = 1'b1;
        o_hit_data = r_mem[idx[IW-1:0]].data;
      end
    end
  end
`endif

endmodule

// File: rtl/cache_mem_bridge.sv
// Merges the cache's split read/write ports onto one RAM port through a write
// buffer. Optional read forwarding from the buffer: CACHE_BRIDGE_FWD_EN.
module cache_mem_bridge
  import cache_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int WB_DEPTH   = WB_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] mwraddress,
  input  logic [DATA_WIDTH-1:0] mdout,
  input  logic                  mwren,
  input  logic [ADDR_WIDTH-1:0] mrdaddress,
  input  logic                  mrden,
  output logic [DATA_WIDTH-1:0] mq,
  output logic                  mq_valid,
  output logic                  mbusy,
  output logic                  wb_overflow,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_write_enable,
  output logic                  ram_read_enable,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  input  logic                  ram_valid_out
);

  bridge_state_t r_state;
  wb_entry_t     w_push_entry;
  wb_entry_t     w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_serve;
  logic          w_rd_acc;
  logic          w_pend;

  assign w_serve      = (r_state == IDLE) || (r_state == DRAIN);
  assign w_rd_acc     = mrden && !mbusy;
  assign w_push       = mwren && (!w_full || w_pop);
  assign w_push_entry = '{addr: mwraddress, data: mdout};
  assign mbusy        = (r_state == RD_ISSUE) || (r_state == RD_WAIT) || w_full || w_pend;

`ifdef CACHE_BRIDGE_FWD_EN
  logic                  w_wb_hit;
  logic [DATA_WIDTH-1:0] w_wb_data;
  logic                  w_same_hit;
  logic                  w_fwd_hit;
  logic [DATA_WIDTH-1:0] w_fwd_data;

  // The same-cycle write is younger than anything already buffered.
  assign w_same_hit = mwren && (mwraddress == mrdaddress);
  assign w_fwd_hit  = w_same_hit || w_wb_hit;
  assign w_fwd_data = w_same_hit ? mdout : w_wb_data;
  assign w_pop      = w_serve && !w_rd_acc && !w_empty;
  assign w_pend     = 1'b0;
`else
  logic                  r_rd_pend;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  w_want_rd;

  // Reads wait behind the whole buffer, so a pop never yields to a read.
  assign w_pop      = w_serve && !w_empty;
  assign w_pend     = r_rd_pend;
  assign w_want_rd  = r_rd_pend || w_rd_acc;
`endif

  write_buffer #(.DEPTH(WB_DEPTH)) u_wb (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty)
`ifdef CACHE_BRIDGE_FWD_EN
    ,
    .i_lookup_addr(mrdaddress),
    .o_hit        (w_wb_hit),
    .o_hit_data   (w_wb_data)
`endif
  );

  // NOTE: all state here is sequential, so every assignment is non-blocking.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state          <= IDLE;
      mq               <= '0;
      mq_valid         <= 1'b0;
      wb_overflow      <= 1'b0;
      ram_address      <= '0;
      ram_data_in      <= '0;
      ram_write_enable <= 1'b0;
      ram_read_enable  <= 1'b0;
`ifndef CACHE_BRIDGE_FWD_EN
      r_rd_pend        <= 1'b0;
      r_rd_addr        <= '0;
`endif
    end else begin
      mq_valid         <= 1'b0;
      ram_write_enable <= 1'b0;
      ram_read_enable  <= 1'b0;
      if (mwren && w_full && !w_pop) wb_overflow <= 1'b1;

      case (r_state)
        IDLE, DRAIN: begin
`ifdef CACHE_BRIDGE_FWD_EN
          if (w_rd_acc && w_fwd_hit) begin
            mq       <= w_fwd_data;
            mq_valid <= 1'b1;
            r_state  <= IDLE;
          end else if (w_rd_acc) begin
            ram_read_enable <= 1'b1;
            ram_address     <= mrdaddress;
            r_state         <= RD_ISSUE;
          end else if (w_pop) begin
            ram_write_enable <= 1'b1;
            ram_address      <= w_head.addr;
            ram_data_in      <= w_head.data;
            r_state          <= DRAIN;
          end else begin
            r_state <= IDLE;
          end
`else
          if (w_rd_acc) begin
            r_rd_pend <= 1'b1;
            r_rd_addr <= mrdaddress;
          end
          if (w_pop) begin
            ram_write_enable <= 1'b1;
            ram_address      <= w_head.addr;
            ram_data_in      <= w_head.data;
            r_state          <= DRAIN;
          end else if (w_want_rd && !(w_rd_acc && w_push)) begin
            ram_read_enable <= 1'b1;
            ram_address     <= w_rd_acc ? mrdaddress : r_rd_addr;
            r_rd_pend       <= 1'b0;
            r_state         <= RD_ISSUE;
          end else if (w_want_rd) begin
            r_state <= DRAIN;
          end else begin
            r_state <= IDLE;
          end
`endif
        end
        RD_ISSUE: r_state <= RD_WAIT;
        RD_WAIT: begin
          if (ram_valid_out) begin
            mq       <= ram_data_out;
            mq_valid <= 1'b1;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cache_mem_bridge.md
# cache_mem_bridge

Sits between the `Cache` memory port and the single-port `Ram`. It merges the cache's split read and write request ports onto one RAM port. A small write buffer absorbs write-backs, so a line fetch issued right after an eviction does not wait for the write to complete. It also returns fill data to the cache with an explicit valid strobe and a busy back-pressure signal.

## Interface
- `ADDR_WIDTH`, 16, word address width on both sides
- `DATA_WIDTH`, 32, data width (one cache block per beat)
- `WB_DEPTH`, 4, write-buffer entries; must be a power of two and at least 2
- `clk` in 1: the single clock; all logic is on its rising edge
- `reset_n` in 1: synchronous, active-low reset
- `mwraddress` in `ADDR_WIDTH`: write-back address from the cache
- `mdout` in `DATA_WIDTH`: write-back data from the cache
- `mwren` in 1: write-back request, one cycle per block
- `mrdaddress` in `ADDR_WIDTH`: fetch address from the cache
- `mrden` in 1: fetch request, one cycle per block
- `mq` out `DATA_WIDTH`: fill data to the cache; holds its value until the next fill
- `mq_valid` out 1: one-cycle strobe; `mq` is valid in this cycle
- `mbusy` out 1: high while a read is outstanding or the buffer is full
- `wb_overflow` out 1: sticky; set when `mwren` arrives while the buffer is full
- `ram_address` out `ADDR_WIDTH`: RAM address
- `ram_data_in` out `DATA_WIDTH`: RAM write data
- `ram_write_enable` out 1: RAM write strobe
- `ram_read_enable` out 1: RAM read strobe
- `ram_data_out` in `DATA_WIDTH`: RAM read data
- `ram_valid_out` in 1: RAM read data valid

## Operation
States are `IDLE`, `RD_ISSUE`, `RD_WAIT` and `DRAIN`.
- **Write accept.** `mwren` with the buffer not full pushes {address, data} into the FIFO. This happens in every state.
  - `mwren` with the buffer full drops the write and sets `wb_overflow`.
  - Only reset clears `wb_overflow`.
- **Read accept.** `mrden` is accepted only when `mbusy` is low. A read that arrives while `mbusy` is high is ignored; it does not queue.
- **Same-cycle events.** When `mwren` and `mrden` occur in the same cycle, the write is logically ordered first. The read therefore observes it.
- **Buffer lookup.** An accepted read searches every valid buffer entry plus the same-cycle write.
  - If several entries match, the youngest match wins.
  - Forward hit: `mq` takes the buffered data and there is no RAM access. The state stays `IDLE`.
  - Miss: go to `RD_ISSUE`.
- **`RD_ISSUE`.** Assert `ram_read_enable` for one cycle, with `ram_address` set to the latched read address. Then go to `RD_WAIT`.
- **`RD_WAIT`.** Hold until `ram_valid_out` is high. Then capture `ram_data_out` into `mq` and return to `IDLE`.
- **`DRAIN`.** Entered from `IDLE` when the buffer is non-empty and no read is accepted that cycle.
  - Pop the head entry and drive `ram_write_enable` for one cycle with the entry's address and data.
  - Pops continue back-to-back, one per cycle.
  - Return to `IDLE` when the buffer is empty or a read is accepted.
  - An accepted read takes priority over the next pop.
- **Port exclusivity.** `ram_read_enable` and `ram_write_enable` are never high in the same cycle.
- **RAM port when idle.** When neither strobe is high, `ram_address` and `ram_data_in` hold their previous values.
- **`mbusy`.** Equals (state is `RD_ISSUE` or `RD_WAIT`) OR (buffer full).
- **FIFO pointers.** Pointers are `log2(WB_DEPTH)+1` bits wide and wrap modulo 2·`WB_DEPTH`.
  - Full means the MSBs differ and the remaining bits are equal.
  - Empty means the pointers are equal.
  - Simultaneous push and pop on a full buffer is allowed: the pop frees the slot in the same cycle.
- **Reset.** Asserting reset in the middle of an operation abandons any outstanding read and discards buffered writes. The RAM is not written.

## Timing
- **Reset values.** `mq`=0, `mq_valid`=0, `mbusy`=0, `wb_overflow`=0, `ram_*_enable`=0, `ram_address`=0, `ram_data_in`=0. State is `IDLE`, buffer empty.
- **Forward hit.** `mrden` in cycle N gives `mq_valid` in cycle N+1.
- **Miss.** `mrden` in cycle N gives `ram_read_enable` in cycle N+1. If `ram_valid_out` is high in cycle M, `mq_valid` is high in cycle M+1.
- **First write drain.** `mwren` in cycle N into an empty, idle buffer gives `ram_write_enable` no earlier than cycle N+2. Cycle N+1 is the `IDLE`→`DRAIN` decision.
- **`mbusy` timing.** `mbusy` is registered. It rises in the cycle after the read accept and falls in the same cycle that `mq_valid` is high.

## Configuration
- `CACHE_BRIDGE_FWD_EN` defined: read forwarding from the write buffer is enabled, as described above.
- `CACHE_BRIDGE_FWD_EN` undefined: there is no lookup logic.
  - An accepted read first drains the entire buffer, including a same-cycle write, with `mbusy` held high.
  - Only then does the read enter `RD_ISSUE`.
  - RAM order therefore always matches request order.

## Structure
- **Package `cache_mem_pkg`.**
  - Holds the state enum `bridge_state_t` and the default width constants.
  - Holds the `wb_entry_t` struct {addr, data}.
- **Sub-module `write_buffer`.**
  - A FIFO of `wb_entry_t`, with push, pop, full and empty.
  - Includes a combinational youngest-match address lookup port, compiled only under `CACHE_BRIDGE_FWD_EN`.
- **Top level.** Holds the FSM, the read latch and the RAM port mux.

## Test plan
1. **Plain fill.** Write `mem[0x0100]`=`0xA5A5_0001` directly, then `mrden` @`0x0100` → exactly one `ram_read_enable` @`0x0100`; `mq`=`0xA5A5_0001`; one `mq_valid` pulse.
2. **Eviction then fetch.** `mwren` @`0x0a00` with data `0x0DDA_4444`, next cycle `mrden` @`0x0c00`.
   - The read is issued before the write drains.
   - RAM later holds `0x0DDA_4444` @`0x0a00`.
3. **Same-cycle forward.** `mwren` @`0x0200` with data `0x1234_5678`, and `mrden` @`0x0200` in the same cycle.
   - With `CACHE_BRIDGE_FWD_EN`: `mq`=`0x1234_5678` one cycle later, with no `ram_read_enable`.
   - Without it: the write drains first, then the RAM read returns `0x1234_5678`.
4. **Full and overflow.** Push 4 writes while a read stalls in `RD_WAIT`, with `ram_valid_out` held low.
   - `mbusy` stays high.
   - A 5th `mwren` sets `wb_overflow`, and that data never reaches RAM.
5. **Reset mid-operation.** With 2 entries buffered and a read in `RD_WAIT`, pulse `reset_n` low for 1 cycle.
   - All outputs return to their reset values.
   - No further RAM strobes occur.
6. **Wrap-around.** Run 9 consecutive write/drain pairs @`0x0300`..`0x0308`. RAM contents match in order, and the pointers wrap cleanly.
